// File: rtl/async_fifo_pkg.sv
// Shared definitions for async_fifo, its read-side consumer and their benches.
package async_fifo_pkg;

  localparam int unsigned DSIZE_DEF = 8;
  localparam int unsigned ASIZE_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;

  // Words currently held in the reader's skid buffer.
  typedef enum logic [1:0] {
    OCC0 = 2'd0,
    OCC1 = 2'd1,
    OCC2 = 2'd2
  } rd_occ_e;

endpackage

// File: rtl/async_fifo_reader.sv
// Read-side consumer of async_fifo: a 2-entry skid buffer turns rempty/rinc/rdata into a
// valid/ready stream. Define ASYNC_FIFO_READER_CNT_EN to add the rd_cnt accepted-word counter.
module async_fifo_reader
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF
`ifdef ASYNC_FIFO_READER_CNT_EN
  ,
  parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data
`ifdef ASYNC_FIFO_READER_CNT_EN
  ,
  output logic [CNT_W-1:0] rd_cnt
`endif
);

  rd_occ_e          occ_q;
  logic [DSIZE-1:0] head_q;
  logic [DSIZE-1:0] tail_q;
  logic             pop;
  logic             take;

  assign m_valid = (occ_q != OCC0);
  assign m_data  = head_q;

  // rinc only looks at registered state and FIFO/flush inputs, never at m_ready.
  always_comb begin
    rinc = !rempty && (occ_q != OCC2) && !flush && rrst_n;
    pop  = rinc;
    take = m_valid && m_ready;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q  <= OCC0;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      occ_q <= OCC0;
    end else begin
      unique case (occ_q)
        OCC0: begin
          if (pop) begin
            head_q <= rdata;
            occ_q  <= OCC1;
          end
        end
        OCC1: begin
          if (pop && take) begin
            head_q <= rdata;
          end else if (pop) begin
            tail_q <= rdata;
            occ_q  <= OCC2;
          end else if (take) begin
            occ_q <= OCC0;
          end
        end
        OCC2: begin
          if (take) begin
            head_q <= tail_q;
            occ_q  <= OCC1;
          end
        end
        default: occ_q <= OCC0;
      endcase
    end
  end

`ifdef ASYNC_FIFO_READER_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Takes in a flush cycle still count; only reset clears the counter.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q <= '0;
    end else if (take) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign rd_cnt = cnt_q;
`endif

  a_occ_legal: assert property (@(posedge rclk) disable iff (!rrst_n)
    occ_q inside {OCC0, OCC1, OCC2});

  a_data_stable: assert property (@(posedge rclk) disable iff (!rrst_n)
    (m_valid && !m_ready && !flush) |=> $stable(m_data));

  a_no_pop_when_full: assert property (@(posedge rclk) disable iff (!rrst_n)
    (occ_q == OCC2) |-> !rinc);

endmodule

// File: tb/tb_async_fifo_reader.sv
// Scoreboard bench for async_fifo_reader fed by a behavioural show-ahead FIFO model.
`timescale 1ns/1ps
module tb_async_fifo_reader;
  import async_fifo_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          rclk    = 1'b0;
  logic          rrst_n  = 1'b0;
  logic          rempty  = 1'b1;
  logic [DW-1:0] rdata   = '0;
  logic          rinc;
  logic          flush   = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
`ifdef ASYNC_FIFO_READER_CNT_EN
  logic [CW-1:0] rd_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int n_take = 0;
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] exp_q[$];
  logic pop_pending = 1'b0;

  async_fifo_reader #(
    .DSIZE(DW)
`ifdef ASYNC_FIFO_READER_CNT_EN
    ,
    .CNT_W(CW)
`endif
  ) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .flush  (flush),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data)
`ifdef ASYNC_FIFO_READER_CNT_EN
    ,
    .rd_cnt (rd_cnt)
`endif
  );

  always #35 rclk = ~rclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // FIFO model: pop on an edge with rinc, registered rempty/rdata update just after the edge.
  always @(negedge rclk) pop_pending = rinc;

  always begin
    @(posedge rclk);
    if (pop_pending && fifo.size() > 0) void'(fifo.pop_front());
    #1;
    rempty = (fifo.size() == 0);
    rdata  = (fifo.size() > 0) ? fifo[0] : '0;
  end

  // Monitor: every accepted word must be the oldest outstanding expected word.
  initial forever begin
    @(negedge rclk);
    if (rrst_n && m_valid && m_ready) begin
      n_take++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra: got %0h expected no word", m_data);
      end else begin
        check("stream_data", m_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge rclk);
      #5;
    end
  endtask

  task automatic send(input logic [DW-1:0] w);
    fifo.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic drain(input string name);
    int i = 0;
    while ((exp_q.size() != 0 || m_valid) && i < 60) begin
      step();
      i++;
    end
    check(name, exp_q.size(), 0);
    check({name, "_idle"}, m_valid, 0);
  endtask

  task automatic watch(input int n, output int rn, output int rrun, output int vn,
                       output int vrun);
    int rc = 0;
    int vc = 0;
    rn = 0; rrun = 0; vn = 0; vrun = 0;
    repeat (n) begin
      @(negedge rclk);
      if (rinc) begin rn++; rc++; if (rc > rrun) rrun = rc; end else rc = 0;
      if (m_valid) begin vn++; vc++; if (vc > vrun) vrun = vc; end else vc = 0;
    end
  endtask

  initial begin
    int rn, rrun, vn, vrun;
`ifdef ASYNC_FIFO_READER_CNT_EN
    logic [CW-1:0] cnt_before;
`endif

    // 1. Reset held with data available and consumer ready.
    rrst_n  = 1'b0;
    m_ready = 1'b1;
    fifo.push_back(8'hEE);
    step(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      check("rst_rempty", rempty, 0);
      check("rst_rinc", rinc, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
    end
    fifo.delete();
    step(2);
    rrst_n = 1'b1;
    step(2);
    check("idle_m_valid", m_valid, 0);
    check("idle_rinc", rinc, 0);

    // 2. Single word.
    send(8'hA5);
    watch(6, rn, rrun, vn, vrun);
    check("t2_rinc_pulses", rn, 1);
    check("t2_valid_cycles", vn, 1);
    step();
    drain("t2_drain");

    // 3. Four words back to back, no bubbles.
    for (int i = 1; i <= 4; i++) send(DW'(i));
    watch(10, rn, rrun, vn, vrun);
    check("t3_rinc_pulses", rn, 4);
    check("t3_rinc_run", rrun, 4);
    check("t3_valid_cycles", vn, 4);
    check("t3_valid_run", vrun, 4);
    step();
    drain("t3_drain");

    // 4. Stalled consumer fills the skid buffer, then releases.
    m_ready = 1'b0;
    send(8'h11); send(8'h22); send(8'h33);
    watch(6, rn, rrun, vn, vrun);
    check("t4_rinc_pulses", rn, 2);
    check("t4_m_valid", m_valid, 1);
    check("t4_m_data_held", m_data, 8'h11);
    check("t4_rempty", rempty, 0);
    check("t4_rinc_full", rinc, 0);
    step();
    m_ready = 1'b1;
    watch(8, rn, rrun, vn, vrun);
    check("t4_rinc_resume", rn, 1);
    step();
    drain("t4_drain");

    // 5. Flush with two words buffered and one left in the FIFO.
    m_ready = 1'b0;
    send(8'h55); send(8'h66); send(8'h77);
    step(6);
    check("t5_m_data", m_data, 8'h55);
    check("t5_rempty", rempty, 0);
    flush = 1'b1;
    #1;
    check("t5_flush_rinc", rinc, 0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    step();
    flush = 1'b0;
    check("t5_valid_after_flush", m_valid, 0);
    m_ready = 1'b1;
    drain("t5_drain");

    // 6. Eight more words under a toggling consumer: seventeen accepted in total.
    for (int i = 0; i < 8; i++) begin
      send(8'h80 + DW'(i));
      m_ready = (i % 2 == 1);
      step();
    end
    m_ready = 1'b1;
    drain("t6_drain");
    check("t6_take_count", n_take, 17);
`ifdef ASYNC_FIFO_READER_CNT_EN
    check("t6_rd_cnt_wrap", rd_cnt, 1);
    cnt_before = rd_cnt;
`endif
    m_ready = 1'b0;
    fifo.push_back(8'hC1);
    fifo.push_back(8'hC2);
    step(5);
    check("t6_full_before_flush", m_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_flush_valid", m_valid, 0);
`ifdef ASYNC_FIFO_READER_CNT_EN
    check("t6_rd_cnt_flush", rd_cnt, cnt_before);
`endif

    // 7. Asynchronous reset with a word buffered.
    send(8'hBB);
    step(3);
    check("t7_valid_before_rst", m_valid, 1);
    @(negedge rclk);
    #10;
    rrst_n = 1'b0;
    #1;
    check("t7_async_valid", m_valid, 0);
    check("t7_async_data", m_data, 0);
    check("t7_async_rinc", rinc, 0);
`ifdef ASYNC_FIFO_READER_CNT_EN
    check("t7_async_cnt", rd_cnt, 0);
`endif
    exp_q.delete();
    step(2);
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    step(2);
    send(8'hDD);
    step();
    drain("t7_recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
